// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: state encoding and default timing parameters for the memory-stage controller
package mem_stage_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 5;
endpackage

// File: rtl/mem_stage_ctrl_timeout.sv
// mem_timeout_cnt: counts BUSY cycles and flags the last cycle before the access is abandoned
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt_q;
  assign expire = cnt_q == CNT_W'(TIMEOUT - 1);
  // clear on issue, advance once per BUSY cycle
  always_ff @(posedge clk)
    cnt_q <= rst | clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: turns X/M load/store/dump requests into a stalled multi-cycle memory handshake
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dataAddrM,
  input  logic [15:0] wrtDataM,
  input  logic        memWrtM,
  input  logic        readEnM,
  input  logic        createDumpM,
  input  logic        memRdy,
  input  logic        memDone,
  input  logic [15:0] memRdata,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  output logic        memDump,
  output logic        stallM,
  output logic [15:0] readDataM,
  output logic        errM
);
  state_e      state_q;
  logic        err_q;
  logic        dump_done_q;
  logic        wr_q;
  logic [15:0] rdata_q;
  logic        req;
  logic        aligned_req;
  logic        issue;
  logic        expire;
  assign req         = (memWrtM | readEnM) & ~err_q;
  assign aligned_req = state_q == IDLE & req & ~dataAddrM[0];
  assign issue       = aligned_req & memRdy;
  assign memReq      = issue;
  assign memWr       = memWrtM;
  assign memAddr     = dataAddrM;
  assign memWdata    = wrtDataM;
  assign stallM      = aligned_req | state_q == BUSY;
  assign memDump     = state_q == IDLE & createDumpM & ~req & ~dump_done_q;
  assign readDataM   = rdata_q;
  assign errM        = err_q;
  mem_timeout_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (issue),
    .en     (state_q == BUSY),
    .expire (expire)
  );
  // access sequencing, sticky error, one-shot dump and load-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      dump_done_q <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (req & dataAddrM[0]) err_q <= 1'b1;
          if (issue) begin
            state_q <= BUSY;
            wr_q    <= memWrtM;
          end
          if (memDump) dump_done_q <= 1'b1;
        end
        BUSY: begin
          if (memDone) begin
            if (!wr_q) rdata_q <= memRdata;
            state_q <= DONE;
          end else if (expire) begin
            err_q   <= 1'b1;
            rdata_q <= 16'h0000;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, directed corner sequences and randomized model comparison
module tb_mem_stage_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataAddrM, wrtDataM, memRdata;
  logic        memWrtM, readEnM, createDumpM, memRdy, memDone;
  logic        memReq, memWr, memDump, stallM, errM;
  logic [15:0] memAddr, memWdata, readDataM;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .dataAddrM(dataAddrM), .wrtDataM(wrtDataM),
    .memWrtM(memWrtM), .readEnM(readEnM), .createDumpM(createDumpM),
    .memRdy(memRdy), .memDone(memDone), .memRdata(memRdata),
    .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWdata(memWdata),
    .memDump(memDump), .stallM(stallM), .readDataM(readDataM), .errM(errM)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set(input logic r_, input logic w_, input logic rd_, input logic dm_,
                     input logic rdy_, input logic dn_, input logic [15:0] a_,
                     input logic [15:0] wd_, input logic [15:0] rdt_);
    rst = r_; memWrtM = w_; readEnM = rd_; createDumpM = dm_;
    memRdy = rdy_; memDone = dn_; dataAddrM = a_; wrtDataM = wd_; memRdata = rdt_;
  endtask
  task automatic do_reset();
    set(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  typedef struct {
    logic w, r, rdy, dn;
    logic [15:0] a, wd, rdt;
    logic e_req, e_wr, e_stall;
    logic [15:0] e_rd;
  } vec_t;
  vec_t tv [12];
  // behavioural reference: an access is "outstanding" for some number of BUSY cycles,
  // then one DONE cycle; errors and the dump are one-way flags until reset
  bit          m_busy, m_done, m_err, m_dumped, m_load, hold, dead, rr;
  int          m_age;
  logic [15:0] m_rd;
  bit          x_req, x_idle, e_req, e_stall, e_dump;
  initial begin
    tv[0]  = '{0,1,1,0,16'h0010,16'h0000,16'h0000, 1,0,1,16'h0000};
    tv[1]  = '{0,1,0,0,16'h0010,16'h0000,16'h0000, 0,0,1,16'h0000};
    tv[2]  = '{0,1,0,0,16'h0010,16'h0000,16'h0000, 0,0,1,16'h0000};
    tv[3]  = '{0,1,0,1,16'h0010,16'h0000,16'hBEEF, 0,0,1,16'h0000};
    tv[4]  = '{0,1,0,0,16'h0010,16'h0000,16'h0000, 0,0,0,16'hBEEF};
    tv[5]  = '{0,0,0,0,16'h0000,16'h0000,16'h0000, 0,0,0,16'hBEEF};
    tv[6]  = '{1,0,0,0,16'h0020,16'h1234,16'h0000, 0,1,1,16'hBEEF};
    tv[7]  = '{1,0,0,0,16'h0020,16'h1234,16'h0000, 0,1,1,16'hBEEF};
    tv[8]  = '{1,0,1,0,16'h0020,16'h1234,16'h0000, 1,1,1,16'hBEEF};
    tv[9]  = '{1,0,0,1,16'h0020,16'h1234,16'h5555, 0,1,1,16'hBEEF};
    tv[10] = '{1,0,0,0,16'h0020,16'h1234,16'h0000, 0,1,0,16'hBEEF};
    tv[11] = '{0,0,0,0,16'h0000,16'h0000,16'h0000, 0,0,0,16'hBEEF};
    @(negedge clk);
    do_reset();
    #1;
    chk("reset stallM", 16'(stallM), 16'h0);
    chk("reset memReq", 16'(memReq), 16'h0);
    chk("reset memDump", 16'(memDump), 16'h0);
    chk("reset readDataM", readDataM, 16'h0000);
    chk("reset errM", 16'(errM), 16'h0);
    @(negedge clk);
    // loads and stores from the table
    for (int i = 0; i < 12; i++) begin
      set(0, tv[i].w, tv[i].r, 0, tv[i].rdy, tv[i].dn, tv[i].a, tv[i].wd, tv[i].rdt);
      #1;
      chk($sformatf("tv%0d memReq", i), 16'(memReq), 16'(tv[i].e_req));
      chk($sformatf("tv%0d stallM", i), 16'(stallM), 16'(tv[i].e_stall));
      chk($sformatf("tv%0d readDataM", i), readDataM, tv[i].e_rd);
      chk($sformatf("tv%0d memAddr", i), memAddr, tv[i].a);
      chk($sformatf("tv%0d memWdata", i), memWdata, tv[i].wd);
      if (tv[i].e_req) chk($sformatf("tv%0d memWr", i), 16'(memWr), 16'(tv[i].e_wr));
      @(negedge clk);
    end
    // misaligned load: sticky error, later aligned request blocked
    do_reset();
    set(0, 0, 1, 0, 1, 0, 16'h0011, 16'h0, 16'h0);
    #1;
    chk("mis memReq", 16'(memReq), 16'h0);
    chk("mis stallM", 16'(stallM), 16'h0);
    @(negedge clk);
    set(0, 0, 1, 0, 1, 0, 16'h0010, 16'h0, 16'h0);
    #1;
    chk("mis errM", 16'(errM), 16'h1);
    chk("mis later memReq", 16'(memReq), 16'h0);
    chk("mis later stallM", 16'(stallM), 16'h0);
    @(negedge clk);
    #1;
    chk("mis errM sticky", 16'(errM), 16'h1);
    @(negedge clk);
    // timeout after a successful load clears readDataM
    do_reset();
    set(0, 0, 1, 0, 1, 0, 16'h0030, 16'h0, 16'h0);
    @(negedge clk);
    set(0, 0, 1, 0, 0, 1, 16'h0030, 16'h0, 16'hA5A5);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    chk("tmo preload", readDataM, 16'hA5A5);
    set(0, 0, 1, 0, 1, 0, 16'h0040, 16'h0, 16'h0);
    #1;
    chk("tmo memReq", 16'(memReq), 16'h1);
    @(negedge clk);
    for (int i = 0; i < TO; i++) begin
      set(0, 0, 1, 0, 0, 0, 16'h0040, 16'h0, 16'h0);
      #1;
      chk($sformatf("tmo busy%0d stallM", i), 16'(stallM), 16'h1);
      chk($sformatf("tmo busy%0d errM", i), 16'(errM), 16'h0);
      @(negedge clk);
    end
    #1;
    chk("tmo done stallM", 16'(stallM), 16'h0);
    chk("tmo done errM", 16'(errM), 16'h1);
    chk("tmo done readDataM", readDataM, 16'h0000);
    @(negedge clk);
    #1;
    chk("tmo idle stallM", 16'(stallM), 16'h0);
    chk("tmo idle memReq", 16'(memReq), 16'h0);
    @(negedge clk);
    // dump waits for the pending load, then pulses exactly once
    do_reset();
    set(0, 0, 1, 1, 1, 0, 16'h0050, 16'h0, 16'h0);
    #1;
    chk("dump issue memReq", 16'(memReq), 16'h1);
    chk("dump issue memDump", 16'(memDump), 16'h0);
    @(negedge clk);
    set(0, 0, 1, 1, 0, 1, 16'h0050, 16'h0, 16'h7777);
    #1;
    chk("dump busy memDump", 16'(memDump), 16'h0);
    @(negedge clk);
    #1;
    chk("dump done memDump", 16'(memDump), 16'h0);
    chk("dump done readDataM", readDataM, 16'h7777);
    @(negedge clk);
    set(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    #1;
    chk("dump pulse", 16'(memDump), 16'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("dump again%0d", i), 16'(memDump), 16'h0);
    end
    @(negedge clk);
    // reset in the middle of an access; the late memDone is ignored
    do_reset();
    set(0, 0, 1, 0, 1, 0, 16'h0060, 16'h0, 16'h0);
    @(negedge clk);
    set(0, 0, 1, 0, 0, 0, 16'h0060, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid busy stallM", 16'(stallM), 16'h1);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'hFFFF);
    #1;
    chk("rstmid stallM", 16'(stallM), 16'h0);
    chk("rstmid memReq", 16'(memReq), 16'h0);
    chk("rstmid readDataM", readDataM, 16'h0000);
    @(negedge clk);
    memDone = 1'b0;
    #1;
    chk("rstmid late readDataM", readDataM, 16'h0000);
    chk("rstmid late errM", 16'(errM), 16'h0);
    @(negedge clk);
    // randomized traffic against the reference
    set(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    {m_busy, m_done, m_err, m_dumped, m_load, hold, dead} = '0;
    m_age = 0;
    m_rd = 16'h0000;
    for (int c = 0; c < 4000; c++) begin
      rr = $urandom_range(0, 99) == 0;
      rst = rr;
      if (!hold) begin
        memWrtM   = $urandom_range(0, 2) == 0;
        readEnM   = $urandom_range(0, 2) == 0;
        dataAddrM = {16'($urandom) & 16'hFFFE} | 16'($urandom_range(0, 39) == 0);
        wrtDataM  = 16'($urandom);
        dead      = $urandom_range(0, 7) == 0;
      end
      memRdy      = $urandom_range(0, 2) != 0;
      memDone     = dead ? 1'b0 : $urandom_range(0, 3) == 0;
      memRdata    = 16'($urandom);
      createDumpM = $urandom_range(0, 15) == 0;
      #1;
      x_req   = (memWrtM | readEnM) & ~m_err;
      x_idle  = ~m_busy & ~m_done;
      e_req   = x_idle & x_req & ~dataAddrM[0] & memRdy;
      e_stall = m_busy | (x_idle & x_req & ~dataAddrM[0]);
      e_dump  = x_idle & createDumpM & ~x_req & ~m_dumped;
      chk("rnd memReq", 16'(memReq), 16'(e_req));
      chk("rnd stallM", 16'(stallM), 16'(e_stall));
      chk("rnd memDump", 16'(memDump), 16'(e_dump));
      chk("rnd readDataM", readDataM, m_rd);
      chk("rnd errM", 16'(errM), 16'(m_err));
      chk("rnd memAddr", memAddr, dataAddrM);
      if (e_req) chk("rnd memWr", 16'(memWr), 16'(memWrtM));
      if (rr) begin
        {m_busy, m_done, m_err, m_dumped} = '0;
        m_rd = 16'h0000;
      end else if (m_busy) begin
        m_age++;
        if (memDone) begin
          if (m_load) m_rd = memRdata;
          m_busy = 0;
          m_done = 1;
        end else if (m_age == TO) begin
          m_err  = 1;
          m_rd   = 16'h0000;
          m_busy = 0;
          m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else begin
        if (x_req & dataAddrM[0]) m_err = 1;
        if (e_req) begin
          m_busy = 1;
          m_age  = 0;
          m_load = ~memWrtM;
        end
        if (e_dump) m_dumped = 1;
      end
      hold = e_stall & ~rr;
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
